rca_serial_ctrl: RTL and testbench

//  Byte-serial 32-bit adder controller that time-multiplexes a single RCA_8bit slice.

---
 rtl/rca_serial_ctrl_pkg.sv | 26 ++
 rtl/rca_serial_ctrl_slice.sv | 24 ++
 rtl/rca_serial_ctrl.sv | 97 +++++++++
 tb/tb_rca_serial_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_serial_ctrl_pkg.sv
// Shared types and constants for the byte-serial adder controller.
// The controller walks one 8-bit ripple slice across the operand, one byte per cycle.
package rca_serial_ctrl_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2, used to size the slice index counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_serial_ctrl_slice.sv
// Purely combinational 8-bit ripple-carry adder slice.
// Reused once per byte by the serial controller.
module rca_serial_ctrl_slice
  import rca_serial_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rca_serial_ctrl.sv
// Byte-serial WIDTH-bit adder: one shared 8-bit slice, registered carry between bytes,
// valid/ready handshakes on operands and result.
module rca_serial_ctrl
  import rca_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e                           state_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [NSLICE-1:0][SLICE_W-1:0]   a_q;
  logic [NSLICE-1:0][SLICE_W-1:0]   b_q;
  logic [NSLICE-1:0][SLICE_W-1:0]   sum_q;
  logic                             carry_q;
  logic                             cout_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  rca_serial_ctrl_slice u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[idx_q] <= slice_sum;
          carry_q      <= slice_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= slice_cout;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // Result is held here until the consumer takes it; no new operands accepted.
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Gated by rst_n so the producer never sees ready while the block is held in reset.
  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Directed bench for rca_serial_ctrl: reset, latency, ripple, backpressure, abort, streaming.
module tb_rca_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  int passed;
  int total;

  rca_serial_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full transaction with out_ready high; checks latency and the result.
  task automatic run_add(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
    step();
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] set_a [3];
  logic [31:0] set_b [3];
  logic        set_c [3];
  int          acc_cyc [3];

  initial begin
    int   acc_idx;
    int   res_idx;
    logic seen_valid;
    logic [32:0] model;

    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // 1: reset
    repeat (3) step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // 2: basic add with explicit per-cycle latency checks
    a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_run_in_ready", {31'b0, in_ready}, 32'd0);
    check("basic_run_busy", {31'b0, busy}, 32'd1);
    repeat (3) step();
    check("basic_c4_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("basic_c5_out_valid", {31'b0, out_valid}, 32'd1);
    check("basic_sum", sum, 32'h0000_0003);
    check("basic_cout", {31'b0, cout}, 32'd0);
    step();
    check("basic_after_out_valid", {31'b0, out_valid}, 32'd0);
    check("basic_after_busy", {31'b0, busy}, 32'd0);
    check("basic_hold_sum", sum, 32'h0000_0003);

    // 3: carry ripples through every slice
    run_add("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);

    // 4: backpressure, with in_valid pulses during DONE
    a = 32'h1234_5678; b = 32'h0FED_CBA8; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = (i % 2 == 0);
      check($sformatf("bp_out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_sum_%0d", i), sum, 32'h2222_2220);
      check($sformatf("bp_cout_%0d", i), {31'b0, cout}, 32'd0);
      step();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0;
    check("bp_idle_busy", {31'b0, busy}, 32'd0);
    check("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_hold_sum", sum, 32'h2222_2220);
    step();
    check("bp_not_latched_busy", {31'b0, busy}, 32'd0);

    // 5: reset mid-RUN aborts the add
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_sum", sum, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_out_valid", {31'b0, seen_valid}, 32'd0);
    check("abort_idle_in_ready", {31'b0, in_ready}, 32'd1);
    run_add("after_abort", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

    // 6: back-to-back with in_valid held high
    set_a[0] = 32'hDEAD_BEEF; set_b[0] = 32'h2152_4111; set_c[0] = 1'b0;
    set_a[1] = 32'h7FFF_FFFF; set_b[1] = 32'h0000_0001; set_c[1] = 1'b0;
    set_a[2] = 32'h0F0F_0F0F; set_b[2] = 32'h0101_0101; set_c[2] = 1'b1;
    acc_idx = 0;
    res_idx = 0;
    a = set_a[0]; b = set_b[0]; cin = set_c[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && res_idx < 3; cyc++) begin
      if (out_valid) begin
        model = {1'b0, set_a[res_idx]} + {1'b0, set_b[res_idx]} + {32'b0, set_c[res_idx]};
        check($sformatf("b2b_sum_%0d", res_idx), sum, model[31:0]);
        check($sformatf("b2b_cout_%0d", res_idx), {31'b0, cout}, {31'b0, model[32]});
        res_idx++;
      end
      if (in_ready && acc_idx < 3) begin
        acc_cyc[acc_idx] = cyc;
        acc_idx++;
      end
      step();
      if (acc_idx < 3) begin
        a = set_a[acc_idx]; b = set_b[acc_idx]; cin = set_c[acc_idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_results", res_idx, 32'd3);
    check("b2b_accepts", acc_idx, 32'd3);
    check("b2b_gap_01", acc_cyc[1] - acc_cyc[0], 32'd6);
    check("b2b_gap_12", acc_cyc[2] - acc_cyc[1], 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
